// File: rtl/blink_pattern_ctrl.sv
// blink_pattern_ctrl: prescaled LED pattern sequencer (count, scan, blink, hold)
module blink_pattern_ctrl #(
  parameter int CLK_DIV = 25000000,
  parameter int DIV_W = 25,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] led,
  output logic             tick
);
  typedef enum logic [1:0] {COUNT, SCAN, BLINK, HOLD} mode_t;
  typedef enum logic {LEFT, RIGHT} dir_t;
  mode_t            mode_q;
  dir_t             dir, dir_nxt;
  logic             step_q, chg, due;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W:0]   lim_s, lim;
  logic [WIDTH-1:0] scan_nxt, step_led, init_led;
  always_comb begin
    lim_s = (DIV_W+1)'(CLK_DIV) >> speed;
    lim = lim_s | (DIV_W+1)'(lim_s == '0);
    chg = mode != mode_q;
    due = run ? ({1'b0, div_cnt} >= lim - 1'b1) : (step & ~step_q);
    scan_nxt = dir == LEFT ? led << 1 : led >> 1;
    dir_nxt = dir == LEFT ? (scan_nxt[WIDTH-1] ? RIGHT : LEFT) : (scan_nxt == WIDTH'(1) ? LEFT : RIGHT);
    step_led = mode_q == COUNT ? led + 1'b1 : mode_q == SCAN ? scan_nxt : mode_q == BLINK ? ~led : led;
    init_led = (mode == COUNT || mode == BLINK) ? '0 : mode == SCAN ? WIDTH'(1) : led;
  end
  always_ff @(posedge clk)
    if (rst) begin
      led <= '0;
      tick <= 1'b0;
      div_cnt <= '0;
      dir <= LEFT;
      mode_q <= COUNT;
      step_q <= 1'b0;
    end else if (!ena) begin
      tick <= 1'b0;
    end else begin
      mode_q <= mode_t'(mode);
      step_q <= step;
      tick <= due & ~chg;
      div_cnt <= (chg || !run || due) ? '0 : div_cnt + 1'b1;
      if (chg) begin
        led <= init_led;
        if (mode == SCAN) dir <= LEFT;
      end else if (due) begin
        led <= step_led;
        if (mode_q == SCAN) dir <= dir_nxt;
      end
    end
endmodule

// File: tb/tb_blink_pattern_ctrl.sv
// tb_blink_pattern_ctrl: scoreboard bench with a behavioural pattern model
module tb_blink_pattern_ctrl;
  localparam int CLK_DIV = 8;
  localparam int DIV_W = 4;
  localparam int W = 8;
  localparam int SCAN_P = 2 * (W - 1);
  logic clk = 0, rst = 1, ena = 1, run = 1, step = 0;
  logic [1:0] mode = 0, speed = 0;
  logic [W-1:0] led;
  logic tick;
  blink_pattern_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .speed(speed),
    .run(run), .step(step), .led(led), .tick(tick)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int c; int v;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit mon_on = 0;
  int m_led = 0, m_el = 0, m_mq = 0, m_sq = 0, m_pos = 0;
  task automatic model_step();
    int lim;
    bit fire;
    if (rst) begin
      m_led = 0; m_el = 0; m_mq = 0; m_sq = 0; m_pos = 0;
      return;
    end
    if (!ena) return;
    lim = CLK_DIV >> speed;
    if (lim == 0) lim = 1;
    if (int'(mode) != m_mq) begin
      case (mode)
        2'd0: m_led = 0;
        2'd1: begin m_led = 1; m_pos = 0; end
        2'd2: m_led = 0;
        default: ;
      endcase
      m_el = 0; m_mq = int'(mode); m_sq = int'(step);
      return;
    end
    fire = 0;
    if (run) begin
      m_el++;
      if (m_el >= lim) begin fire = 1; m_el = 0; end
    end else begin
      m_el = 0;
      fire = step && m_sq == 0;
    end
    m_sq = int'(step);
    if (fire) begin
      case (m_mq)
        0: m_led = (m_led + 1) % (1 << W);
        1: begin
          m_pos = (m_pos + 1) % SCAN_P;
          m_led = 1 << ((m_pos < W) ? m_pos : SCAN_P - m_pos);
        end
        2: m_led = m_led ^ ((1 << W) - 1);
        default: ;
      endcase
      q.push_back('{cyc + 1, m_led});
    end
  endtask
  task automatic go(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask
  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 64) begin go(1); n++; end
    if (tick !== 1'b1) begin
      total++; bad++;
      $display("FAIL tick_timeout cyc=%0d got=0 exp=1", cyc);
    end
  endtask
  always @(negedge clk) if (mon_on) begin
    total++;
    if (led !== W'(m_led)) begin
      bad++;
      $display("FAIL led cyc=%0d got=%h exp=%h", cyc, led, W'(m_led));
    end
    if (q.size() > 0 && q[0].c < cyc) begin
      total++; bad++;
      $display("FAIL missed_tick cyc=%0d got=none exp_cyc=%0d", cyc, q[0].c);
      void'(q.pop_front());
    end
    if (tick !== 1'b0) begin
      total++;
      if (q.size() > 0 && q[0].c == cyc) begin
        if (led !== W'(q[0].v)) begin
          bad++;
          $display("FAIL tick_led cyc=%0d got=%h exp=%h", cyc, led, W'(q[0].v));
        end
        void'(q.pop_front());
      end else begin
        bad++;
        $display("FAIL unexpected_tick cyc=%0d got=%b exp=0", cyc, tick);
      end
    end
  end
  initial begin
    bit seen80;
    int n;
    rst = 1;
    go(2);
    rst = 0;
    mon_on = 1;
    go(8 * 256);
    check("count_wrap", led, 8'h00);
    mode = 1;
    go(1);
    check("scan_init", led, 8'h01);
    check("scan_init_tick", W'(tick), 8'h00);
    go(8 * 20);
    speed = 3;
    go(10);
    speed = 2;
    go(10);
    speed = 0;
    wait_tick();
    go(6);
    speed = 2;
    go(1);
    check("speedup_tick", W'(tick), 8'h01);
    go(6);
    speed = 0;
    mode = 0;
    go(1);
    n = 0;
    while (led !== 8'h05 && n < 200) begin go(1); n++; end
    check("reach5", led, 8'h05);
    run = 0;
    go(2);
    step = 1;
    go(10);
    check("step_held", led, 8'h06);
    step = 0;
    go(2);
    step = 1;
    go(2);
    check("step_again", led, 8'h07);
    step = 0;
    run = 1;
    go(1);
    wait_tick();
    go(7);
    mode = 2;
    go(1);
    check("chg_prio_led", led, 8'h00);
    check("chg_prio_tick", W'(tick), 8'h00);
    go(8);
    check("blink_on", led, 8'hFF);
    go(8);
    check("blink_off", led, 8'h00);
    mode = 1;
    go(1);
    seen80 = 0;
    n = 0;
    while (!(seen80 && led === 8'h20) && n < 400) begin
      go(1);
      if (led === 8'h80) seen80 = 1;
      n++;
    end
    check("scan_at20", led, 8'h20);
    ena = 0;
    go(20);
    check("frozen_led", led, 8'h20);
    check("frozen_tick", W'(tick), 8'h00);
    ena = 1;
    rst = 1;
    go(1);
    check("rst_led", led, 8'h00);
    rst = 0;
    go(1);
    check("rst_chg_scan", led, 8'h01);
    repeat (3000) begin
      if ($urandom_range(99) < 2) mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 3) speed = 2'($urandom_range(3));
      if ($urandom_range(99) < 2) run = ~run;
      if ($urandom_range(99) < 20) step = ~step;
      ena = $urandom_range(99) >= 10;
      rst = $urandom_range(999) < 3;
      go(1);
    end
    rst = 0;
    ena = 1;
    run = 1;
    go(20);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blink_pattern_ctrl.md
Name: blink_pattern_ctrl

Overview:
Sequencer for the LED/counter datapath on the tt_um top level. It owns the step prescaler and drives an 8-bit LED register with one of four selectable patterns: binary count, bouncing scan, blink, hold. Pattern, speed, run/pause and single-step come from ui_in bits. Its led output drives uo_out directly.

Parameters:
CLK_DIV, 25000000, clk cycles per pattern step at speed=0 (must be >= 1)
DIV_W, 25, prescaler counter width (must hold CLK_DIV-1)
WIDTH, 8, LED register width (must be >= 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ena  input  1  design enable; 0 freezes all state
mode  input  2  pattern select: 0 COUNT, 1 SCAN, 2 BLINK, 3 HOLD
speed  input  2  rate select; step period = CLK_DIV >> speed
run  input  1  1 = free-running, 0 = paused (single-step only)
step  input  1  level; each rising edge while paused gives one step
led  output  WIDTH  pattern register (to uo_out)
tick  output  1  one-cycle pulse, high in the same cycle led shows a new step value

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled only on posedge clk; rst overrides ena.
- Reset values: led=0, tick=0, div_cnt=0, dir=LEFT, mode_q=0, step_q=0.
- All state updates only on posedge clk with ena=1. With ena=0 everything holds, including mode_q and step_q, and tick=0.
- limit = CLK_DIV >> speed. If that result is 0, limit is forced to 1.
- Prescaler when run=1:
  - step_due = (div_cnt >= limit-1).
  - When step_due, div_cnt <= 0; otherwise div_cnt increments.
  - The >= compare makes a speed increase mid-count fire on the next cycle, with no overflow wait.
- Paused when run=0:
  - div_cnt <= 0 and holds.
  - step_due = step & ~step_q, where step_q is step registered every enabled cycle.
  - A held step level gives exactly one step.
- Mode change: chg = (mode != mode_q); mode_q <= mode every enabled cycle.
  - When chg: div_cnt <= 0, tick <= 0, and led loads the init value for the new mode. Init values: COUNT 0, SCAN 1 (bit0) with dir=LEFT, BLINK 0, HOLD keeps current led.
  - chg has priority over a coincident step_due; that step is dropped.
- Step action when step_due and !chg, registered, so visible the next cycle together with tick=1:
  - COUNT: led <= led+1, modulo 2^WIDTH (all-ones wraps to 0).
  - SCAN, dir LEFT: led <= led<<1. If the new led has its MSB set, dir <= RIGHT.
  - SCAN, dir RIGHT: led <= led>>1. If the new led = 1, dir <= LEFT.
  - SCAN sequence: 01,02,...,80,40,...,02,01,02,...; period 2*(WIDTH-1) steps; led stays one-hot.
  - SCAN with a non-one-hot led: entering SCAN always reinitialises, so this cannot occur after reset.
  - BLINK: led <= ~led (0x00 <-> 0xFF).
  - HOLD: led unchanged, and tick still pulses (bench-visible heartbeat).
- tick is 0 in every cycle not following a step action.
- Latency: step_due in cycle N gives led/tick updated at the edge ending N, visible in N+1. At speed=0 and run=1, tick period is exactly limit cycles.
- Reset mid-operation: any state, rst=1 for one edge restores all reset values. First tick comes limit cycles after rst deasserts (run=1, mode=0).

Test Plan:
1. CLK_DIV=8, rst 2 cycles, then run=1, mode=0, speed=0 -> led=0 at reset; tick every 8 cycles; led 1,2,3...; after 256 ticks led=0x00 (wrap).
2. CLK_DIV=8, mode 0->1 -> led=0x01 the cycle after the change; ticks give 02,04,...,80,40,...,01,02; 14-tick period; no tick in the change cycle.
3. CLK_DIV=8, speed=3 -> limit 1, tick every cycle. speed=2 -> every 2 cycles. Switch speed 0->2 while div_cnt=6 -> tick on the next cycle, then every 2.
4. run=0, mode=0, led=5; step held high 10 cycles -> exactly one tick, led=6, div_cnt stays 0. Step low then high again -> led=7.
5. mode 0->2 applied in the exact cycle step_due fires -> led=0x00, no tick, div_cnt=0; next tick after 8 cycles -> led=0xFF, then 0x00.
6. In SCAN at led=0x20 dir=RIGHT, drop ena for 20 cycles -> led, div_cnt, tick frozen (tick=0). Then assert rst one cycle -> led=0, dir=LEFT, mode_q=0; with mode=1 held, next cycle chg -> led=0x01.
